// File: rtl/pfb_coeff_loader.sv
// Coefficient reload consumer: reorders the natural-order reload stream into polyphase
// order, fills the shadow bank of a double-buffered coefficient RAM and swaps banks when safe.
module pfb_coeff_loader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COEFF_WIDTH = 25
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [11:0]            fft_size,
  input  logic [7:0]             taps_per_phase,
  input  logic                   swap_ok,
  input  logic [31:0]            s_axis_reload_tdata,
  input  logic                   s_axis_reload_tlast,
  input  logic                   s_axis_reload_tvalid,
  output logic                   s_axis_reload_tready,
  output logic                   coef_wr_en,
  output logic [ADDR_WIDTH:0]    coef_wr_addr,
  output logic [COEFF_WIDTH-1:0] coef_wr_data,
  output logic                   bank_sel,
  output logic                   load_done,
  output logic                   load_err,
  output logic [ADDR_WIDTH:0]    num_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, WAIT_SWAP} state_t;

  state_t state, next_state;

  logic [11:0]           m_reg, phase, cur_m, cur_phase, nxt_phase;
  logic [7:0]            t_reg, tap, cur_t, cur_tap, nxt_tap;
  logic [ADDR_WIDTH-1:0] base, cur_base, nxt_base, cur_addr;
  logic [ADDR_WIDTH:0]   n_reg, beat_cnt;
  logic [19:0]           n_prod;
  logic                  n_ok, hs;
  logic                  do_write, cfg_load, err_set, done_set;
  logic                  unused_tdata_bits;

  assign n_prod = 20'(fft_size) * 20'(taps_per_phase);
  assign n_ok   = (n_prod != 20'd0) && ({12'd0, n_prod} <= (32'd1 << ADDR_WIDTH));

  assign s_axis_reload_tready = !sync_reset && (state != WAIT_SWAP);
  assign hs = s_axis_reload_tvalid && s_axis_reload_tready;
  assign unused_tdata_bits = ^s_axis_reload_tdata[31:COEFF_WIDTH];

  always_ff @(posedge clk) begin
    if (sync_reset) state <= IDLE;
    else            state <= next_state;
  end

  // The first beat of a load is addressed from the live config, later beats from the sampled copy.
  always_comb begin
    next_state = state;
    do_write   = 1'b0;
    cfg_load   = 1'b0;
    err_set    = 1'b0;
    done_set   = 1'b0;
    cur_m      = m_reg;
    cur_t      = t_reg;
    cur_phase  = phase;
    cur_tap    = tap;
    cur_base   = base;
    case (state)
      IDLE: begin
        if (hs) begin
          cfg_load  = 1'b1;
          cur_m     = fft_size;
          cur_t     = taps_per_phase;
          cur_phase = '0;
          cur_tap   = '0;
          cur_base  = '0;
          if (!n_ok) begin
            if (s_axis_reload_tlast) err_set = 1'b1;
            else                     next_state = DRAIN;
          end else begin
            do_write = 1'b1;
            if (s_axis_reload_tlast) begin
              if (n_prod == 20'd1) next_state = WAIT_SWAP;
              else                 err_set = 1'b1;
            end else if (n_prod == 20'd1) begin
              next_state = DRAIN;
            end else begin
              next_state = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (hs) begin
          do_write = 1'b1;
          if (beat_cnt == n_reg - 1'b1) begin
            next_state = s_axis_reload_tlast ? WAIT_SWAP : DRAIN;
          end else if (s_axis_reload_tlast) begin
            err_set    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      DRAIN: begin
        if (hs && s_axis_reload_tlast) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_SWAP: begin
        if (swap_ok) begin
          done_set   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    cur_addr = cur_base + ADDR_WIDTH'(cur_tap);
    if (cur_phase == cur_m - 12'd1) begin
      nxt_phase = '0;
      nxt_base  = '0;
      nxt_tap   = cur_tap + 8'd1;
    end else begin
      nxt_phase = cur_phase + 12'd1;
      nxt_base  = cur_base + ADDR_WIDTH'(cur_t);
      nxt_tap   = cur_tap;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      m_reg        <= '0;
      t_reg        <= '0;
      n_reg        <= '0;
      beat_cnt     <= '0;
      phase        <= '0;
      tap          <= '0;
      base         <= '0;
      coef_wr_en   <= 1'b0;
      coef_wr_addr <= '0;
      coef_wr_data <= '0;
      bank_sel     <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      num_loaded   <= '0;
    end else begin
      if (cfg_load) begin
        m_reg    <= fft_size;
        t_reg    <= taps_per_phase;
        n_reg    <= n_ok ? (ADDR_WIDTH+1)'(n_prod) : '0;
        beat_cnt <= (ADDR_WIDTH+1)'(1);
      end else if (hs && state == LOAD) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (do_write) begin
        phase        <= nxt_phase;
        tap          <= nxt_tap;
        base         <= nxt_base;
        coef_wr_addr <= {~bank_sel, cur_addr};
        coef_wr_data <= s_axis_reload_tdata[COEFF_WIDTH-1:0];
      end
      coef_wr_en <= do_write;
      load_err   <= err_set;
      load_done  <= done_set;
      // Swap only from WAIT_SWAP, one cycle after the final write has been issued.
      if (done_set) begin
        bank_sel   <= ~bank_sel;
        num_loaded <= n_reg;
      end
    end
  end

endmodule

// File: tb/tb_pfb_coeff_loader.sv
// Randomized bench for pfb_coeff_loader: a reference model maps beat k to
// address (k mod M)*T + k div M and tracks bank, load count and pulse totals.
`timescale 1ns/1ps
module tb_pfb_coeff_loader;
  localparam int AW = 16;
  localparam int CW = 25;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic [11:0]   fft_size;
  logic [7:0]    taps_per_phase;
  logic          swap_ok;
  logic [31:0]   s_axis_reload_tdata;
  logic          s_axis_reload_tlast;
  logic          s_axis_reload_tvalid;
  logic          s_axis_reload_tready;
  logic          coef_wr_en;
  logic [AW:0]   coef_wr_addr;
  logic [CW-1:0] coef_wr_data;
  logic          bank_sel;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   num_loaded;

  always #5 clk = ~clk;

  pfb_coeff_loader #(.ADDR_WIDTH(AW), .COEFF_WIDTH(CW)) dut (
    .clk(clk), .sync_reset(sync_reset), .fft_size(fft_size), .taps_per_phase(taps_per_phase),
    .swap_ok(swap_ok), .s_axis_reload_tdata(s_axis_reload_tdata),
    .s_axis_reload_tlast(s_axis_reload_tlast), .s_axis_reload_tvalid(s_axis_reload_tvalid),
    .s_axis_reload_tready(s_axis_reload_tready), .coef_wr_en(coef_wr_en),
    .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data), .bank_sel(bank_sel),
    .load_done(load_done), .load_err(load_err), .num_loaded(num_loaded)
  );

  typedef struct {
    logic [AW:0]   addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   compared = 0, mismatched = 0;
  int   done_seen = 0, err_seen = 0, exp_done = 0, exp_err = 0;
  logic model_bank = 1'b0;
  int   model_num = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [AW:0] modelAddr(input logic bank, input int k, input int m, input int t);
    return {bank, AW'((k % m) * t + k / m)};
  endfunction

  // Write scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_done === 1'b1) done_seen++;
    if (load_err === 1'b1) err_seen++;
    if (coef_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_wr", 32'(coef_wr_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(coef_wr_addr), 32'(mon_e.addr));
        checkOutput("wr_data", 32'(coef_wr_data), 32'(mon_e.data));
      end
    end
  end

  task automatic sendBeat(input logic [31:0] d, input logic last);
    int   waited = 0;
    logic rdy;
    s_axis_reload_tvalid = 1'b1;
    s_axis_reload_tdata  = d;
    s_axis_reload_tlast  = last;
    forever begin
      @(negedge clk);
      rdy = s_axis_reload_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        checkOutput("tready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_axis_reload_tvalid = 1'b0;
    s_axis_reload_tlast  = 1'b0;
  endtask

  task automatic applyStimulus(input int m, input int t, input int len, input int swap_delay,
                               input bit timing, input bit seq_data, input bit gaps, input int abort_at);
    int          n, cnt;
    bit          valid, success;
    logic        prev_bank, new_bank;
    logic [31:0] d;
    wr_t         w;
    n         = m * t;
    valid     = (n > 0) && (n <= 65536);
    success   = valid && (len == n);
    prev_bank = model_bank;
    new_bank  = ~model_bank;
    fft_size       = 12'(m);
    taps_per_phase = 8'(t);
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) return;
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      d = seq_data ? (($urandom & 32'hFE00_0000) | 32'(k)) : $urandom;
      if (valid && k < n) begin
        w.addr = modelAddr(new_bank, k, m, t);
        w.data = d[CW-1:0];
        exp_q.push_back(w);
      end
      if (k == len - 1 && swap_delay > 0) swap_ok = 1'b0;
      sendBeat(d, k == len - 1);
      if (k == 0) begin
        fft_size       = 12'($urandom);
        taps_per_phase = 8'($urandom);
      end
    end
    if (success) begin
      model_bank = new_bank;
      model_num  = n;
      exp_done++;
    end else begin
      exp_err++;
    end
    if (timing && success) begin
      @(negedge clk);
      checkOutput("bank_hold", 32'(bank_sel), 32'(prev_bank));
      @(negedge clk);
      checkOutput("bank_swap", 32'(bank_sel), 32'(new_bank));
      checkOutput("done_pulse", 32'(load_done), 32'd1);
    end
    if (swap_delay > 0) begin
      cnt = 0;
      repeat (swap_delay) begin
        @(negedge clk);
        if (s_axis_reload_tready) cnt++;
      end
      if (success) begin
        checkOutput("wait_tready", 32'(cnt), 32'd0);
        checkOutput("bank_wait", 32'(bank_sel), 32'(prev_bank));
      end
      @(posedge clk);
      #1;
      swap_ok = 1'b1;
    end
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("done_count", 32'(done_seen), 32'(exp_done));
    checkOutput("err_count", 32'(err_seen), 32'(exp_err));
    checkOutput("bank_sel", 32'(bank_sel), 32'(model_bank));
    checkOutput("num_loaded", 32'(num_loaded), 32'(model_num));
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_tready", 32'(s_axis_reload_tready), 32'd0);
    checkOutput("rst_wr_en", 32'(coef_wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(coef_wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(coef_wr_data), 32'd0);
    checkOutput("rst_bank", 32'(bank_sel), 32'd0);
    checkOutput("rst_num", 32'(num_loaded), 32'd0);
    checkOutput("rst_done", 32'(load_done), 32'd0);
    checkOutput("rst_err", 32'(load_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int m, t, n, len, r;
    sync_reset           = 1'b1;
    fft_size             = '0;
    taps_per_phase       = '0;
    swap_ok              = 1'b1;
    s_axis_reload_tdata  = '0;
    s_axis_reload_tlast  = 1'b0;
    s_axis_reload_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset();
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    @(negedge clk);
    checkOutput("tready_after_rst", 32'(s_axis_reload_tready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] nominal load M=8 T=4");
    applyStimulus(8, 4, 32, 0, 1, 1, 0, -1);
    settle();

    $display("[TB] delayed swap with back-to-back reload");
    applyStimulus(8, 4, 32, 10, 0, 1, 0, -1);
    applyStimulus(8, 4, 32, 0, 0, 0, 0, -1);
    settle();

    $display("[TB] short, long and oversize loads");
    applyStimulus(8, 4, 21, 0, 0, 0, 0, -1);
    settle();
    applyStimulus(8, 4, 32, 0, 0, 0, 0, -1);
    settle();
    applyStimulus(8, 4, 40, 0, 0, 0, 0, -1);
    settle();
    applyStimulus(2048, 64, 50, 0, 0, 0, 0, -1);
    settle();
    applyStimulus(2049, 32, 5, 0, 0, 0, 0, -1);
    settle();
    applyStimulus(0, 5, 3, 0, 0, 0, 0, -1);
    settle();
    applyStimulus(1, 1, 1, 0, 0, 0, 0, -1);
    settle();
    applyStimulus(1, 1, 3, 0, 0, 0, 0, -1);
    settle();

    $display("[TB] reset during a load");
    applyStimulus(8, 4, 32, 0, 0, 0, 0, 10);
    sync_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkReset();
    model_bank = 1'b0;
    model_num  = 0;
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    applyStimulus(8, 4, 32, 0, 0, 0, 0, -1);
    settle();

    $display("[TB] randomized loads");
    for (int i = 0; i < 20; i++) begin
      m = $urandom_range(1, 16);
      t = $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) m = 0;
      n = m * t;
      r = $urandom_range(0, 9);
      if (n == 0)     len = $urandom_range(1, 4);
      else if (r < 6) len = n;
      else if (r < 8) len = $urandom_range(1, n);
      else            len = n + $urandom_range(1, 5);
      applyStimulus(m, t, len, $urandom_range(0, 3), 0, 0, 1, -1);
      settle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
